// File: rtl/hello_rot_decoder.sv
// ---------------------------------------------------------------------------
// hello_rot_decoder: recovers the "   HELLO" rotation index from a serial
// stream of eight 7-segment codes.                              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hello_rot_decoder #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [7:0] SEG_IN,
  input  logic       SEG_VALID,
  output logic       SEG_READY,
  output logic [2:0] ROT,
  output logic       ROT_VALID,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  output logic [7:0] FRAME_OK
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  localparam logic [2:0]  SYM_V    = 3'd0;
  localparam logic [2:0]  SYM_H    = 3'd1;
  localparam logic [2:0]  SYM_E    = 3'd2;
  localparam logic [2:0]  SYM_L    = 3'd3;
  localparam logic [2:0]  SYM_O    = 3'd4;
  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYC - 1);

  // Returns {bad, symbol}; bad codes report the blank symbol alongside the bad flag.
  function automatic logic [3:0] decode(input logic [7:0] c);
    case (c)
      8'h89:   return {1'b0, SYM_H};
      8'h86:   return {1'b0, SYM_E};
      8'hC7:   return {1'b0, SYM_L};
      8'hC0:   return {1'b0, SYM_O};
      8'hFF:   return {1'b0, SYM_V};
      default: return {1'b1, SYM_V};
    endcase
  endfunction

  function automatic logic [2:0] ref_sym(input logic [2:0] i);
    case (i)
      3'd3:       return SYM_H;
      3'd4:       return SYM_E;
      3'd5, 3'd6: return SYM_L;
      3'd7:       return SYM_O;
      default:    return SYM_V;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [7:0][2:0] sym_q, sym_d;
  logic [7:0]      bad_q, bad_d;
  logic [2:0]      idx_q, idx_d;
  logic [15:0]     gap_q, gap_d;
  logic [2:0]      rot_q, rot_d;
  logic            rot_valid_q, rot_valid_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [7:0]      frame_ok_q, frame_ok_d;

  logic            accept;
  logic [3:0]      dec;
  logic [2:0]      h_pos;
  logic [2:0]      k_calc;
  logic            match;

  assign SEG_READY = (state_q != ST_CHECK);
  assign accept    = SEG_VALID && SEG_READY;

  always_comb begin
    dec = decode(SEG_IN);

    // H is unique in the reference, so its position fixes the candidate k.
    h_pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sym_q[i] == SYM_H) h_pos = 3'(i);
    end
    k_calc = 3'd3 - h_pos;
    match  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (sym_q[i] != ref_sym(k_calc + 3'(i))) match = 1'b0;
    end

    state_d     = state_q;
    sym_d       = sym_q;
    bad_d       = bad_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    rot_d       = rot_q;
    rot_valid_d = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    frame_ok_d  = frame_ok_q;

    case (state_q)
      ST_IDLE: begin
        gap_d = 16'd0;
        if (accept) begin
          sym_d[0] = dec[2:0];
          bad_d    = {7'd0, dec[3]};
          idx_d    = 3'd1;
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          sym_d[idx_q] = dec[2:0];
          bad_d[idx_q] = dec[3];
          idx_d        = idx_q + 3'd1;
          gap_d        = 16'd0;
          if (idx_q == 3'd7) state_d = ST_CHECK;
        end else if (gap_q == GAP_LAST) begin
          err_d      = 1'b1;
          err_code_d = 2'b11;
          gap_d      = 16'd0;
          idx_d      = 3'd0;
          state_d    = ST_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
        if (|bad_q) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else if (match) begin
          rot_d       = k_calc;
          rot_valid_d = 1'b1;
          frame_ok_d  = frame_ok_q + 8'd1;
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      sym_q       <= '0;
      bad_q       <= '0;
      idx_q       <= 3'd0;
      gap_q       <= 16'd0;
      rot_q       <= 3'd0;
      rot_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      frame_ok_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      bad_q       <= bad_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      rot_q       <= rot_d;
      rot_valid_q <= rot_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      frame_ok_q  <= frame_ok_d;
    end
  end

  assign ROT       = rot_q;
  assign ROT_VALID = rot_valid_q;
  assign ERR       = err_q;
  assign ERR_CODE  = err_code_q;
  assign FRAME_OK  = frame_ok_q;

endmodule

`default_nettype wire

// File: tb/tb_hello_rot_decoder.sv
// ---------------------------------------------------------------------------
// tb_hello_rot_decoder: directed frames with a queue-based scoreboard.
//                                                                Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hello_rot_decoder;

  localparam int TMO = 16;
  // Reference string, digit 0 (HEX7) in the low byte: V V V H E L L O.
  localparam logic [63:0] S_STR = {8'hC0, 8'hC7, 8'hC7, 8'h86,
                                   8'h89, 8'hFF, 8'hFF, 8'hFF};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'hFF;
  logic       seg_valid = 1'b0;
  logic       seg_ready;
  logic [2:0] rot;
  logic       rot_valid;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] frame_ok;

  hello_rot_decoder #(.TIMEOUT_CYC(TMO)) dut (
    .CLOCK_50 (clk),
    .RST_N    (rst_n),
    .SEG_IN   (seg_in),
    .SEG_VALID(seg_valid),
    .SEG_READY(seg_ready),
    .ROT      (rot),
    .ROT_VALID(rot_valid),
    .ERR      (err),
    .ERR_CODE (err_code),
    .FRAME_OK (frame_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [2:0] rot;
    logic [7:0] fok;
    int         edge_no;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ready_low = 0;
  int   last_acc = 0;
  int   last_pulse = 0;

  logic [2:0] m_rot = 3'd0;
  logic [1:0] m_code = 2'd0;
  logic [7:0] m_fok = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!seg_ready) ready_low++;
      if (rot_valid || err) begin
        last_pulse = cyc;
        chk("no_overlap", {31'd0, rot_valid & err}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: rot_valid=%0b err=%0b with empty scoreboard", rot_valid, err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_kind_err", {31'd0, err}, {31'd0, e.is_err});
          chk("err_code", {30'd0, err_code}, {30'd0, e.code});
          chk("rot", {29'd0, rot}, {29'd0, e.rot});
          chk("frame_ok", {24'd0, frame_ok}, {24'd0, e.fok});
          if (e.edge_no >= 0) chk("pulse_edge", cyc, e.edge_no);
        end
      end
    end
  end

  function automatic logic [63:0] rot_frame(input int k);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = S_STR[8*((k + i) % 8) +: 8];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] c);
    int w;
    w = 0;
    seg_in    = c;
    seg_valid = 1'b1;
    while (!seg_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!seg_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_wait: SEG_READY=%0b after %0d cycles, required 1", seg_ready, w);
    end
    @(posedge clk);
    #1 last_acc = cyc;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send(f[8*i +: 8]);
  endtask

  task automatic push_good(input logic [2:0] k);
    exp_t e;
    m_rot = k;
    m_fok = m_fok + 8'd1;
    e = '{is_err: 1'b0, code: m_code, rot: m_rot, fok: m_fok, edge_no: -1};
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c, input int edge_no);
    exp_t e;
    m_code = c;
    e = '{is_err: 1'b1, code: m_code, rot: m_rot, fok: m_fok, edge_no: edge_no};
    sb.push_back(e);
  endtask

  task automatic drain();
    int w;
    w = 0;
    seg_valid = 1'b0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never seen, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int r0;
    int first_acc;
    logic [63:0] f;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, seg_ready}, 32'd1);
    chk("rst_rot", {29'd0, rot}, 32'd0);
    chk("rst_frame_ok", {24'd0, frame_ok}, 32'd0);
    chk("rst_pulses", {30'd0, rot_valid, err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All rotations back to back
    r0 = ready_low;
    send(rot_frame(0)[7:0]);
    first_acc = last_acc;
    for (int i = 1; i < 8; i++) send(rot_frame(0)[8*i +: 8]);
    push_good(3'd0);
    for (int k = 1; k < 8; k++) begin
      send_frame(rot_frame(k));
      push_good(3'(k));
    end
    drain();
    chk("all_rot_frame_ok", {24'd0, frame_ok}, 32'd8);
    chk("all_rot_ready_low", ready_low - r0, 32'd8);
    chk("all_rot_cycles", last_pulse - first_acc + 1, 32'd72);

    // Bad symbol: k=2 with digit 3 replaced by 0x00
    f = rot_frame(2);
    f[31:24] = 8'h00;
    send_frame(f);
    push_err(2'b01, -1);
    drain();
    send_frame(rot_frame(5));
    push_good(3'd5);
    drain();

    // Not a rotation: V V V H E L O L
    send_frame({8'hC7, 8'hC0, 8'hC7, 8'h86, 8'h89, 8'hFF, 8'hFF, 8'hFF});
    push_err(2'b10, -1);
    drain();

    // Timeout after 3 digits
    for (int i = 0; i < 3; i++) send(rot_frame(7)[8*i +: 8]);
    seg_valid = 1'b0;
    push_err(2'b11, last_acc + TMO);
    drain();
    send_frame(rot_frame(7));
    push_good(3'd7);
    drain();

    // Reset mid-frame
    for (int i = 0; i < 5; i++) send(rot_frame(4)[8*i +: 8]);
    seg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, seg_ready}, 32'd1);
    chk("async_rst_rot", {29'd0, rot}, 32'd0);
    chk("async_rst_frame_ok", {24'd0, frame_ok}, 32'd0);
    chk("async_rst_err_code", {30'd0, err_code}, 32'd0);
    m_rot = 3'd0;
    m_code = 2'd0;
    m_fok = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(rot_frame(1));
    push_good(3'd1);
    drain();
    chk("post_rst_frame_ok", {24'd0, frame_ok}, 32'd1);
    chk("post_rst_rot", {29'd0, rot}, 32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
